// File: rtl/bram_sweep_tester.sv
// Write/read-back sweep sequencer for a 1-cycle-latency RAM that has no write enable.
// It fills the RAM with a selectable pattern, reads every word back and tallies mismatches.
module bram_sweep_tester #(
    parameter int WID_MEM   = 1,
    parameter int DEPTH_MEM = 128,
    parameter int ADDR_W    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ADDR_W:0]    err_count,
    output logic [ADDR_W-1:0]  first_err_addr,
    output logic [ADDR_W-1:0]  raddr,
    output logic [ADDR_W-1:0]  waddr,
    output logic [WID_MEM-1:0] din,
    input  logic [WID_MEM-1:0] dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH_MEM - 1);
    localparam logic [ADDR_W:0]   ERR_MAX   = (ADDR_W+1)'(DEPTH_MEM);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   first_q, first_d;

    logic                addr_last;
    logic                cmp_en;
    logic [ADDR_W-1:0]   cmp_addr;
    logic                mismatch;

    function automatic logic [WID_MEM-1:0] pat(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [WID_MEM+ADDR_W-1:0] inv_ext;
        logic [WID_MEM-1:0]        r;
        inv_ext = {{WID_MEM{1'b0}}, ~a};
        r = '0;
        for (int j = 0; j < WID_MEM; j++) begin
            case (m)
                2'd0:    r[j] = 1'b0;
                2'd1:    r[j] = 1'b1;
                2'd2:    r[j] = a[0] ^ j[0];
                default: r[j] = inv_ext[j];
            endcase
        end
        return r;
    endfunction

    // State register: every flop of the block lives here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            mode_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign addr_last = (addr_q == ADDR_LAST);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_WRITE;
            S_WRITE:        if (addr_last) state_d = S_READ;
            S_READ:         if (addr_last) state_d = S_DRAIN;
            S_DRAIN:        state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // dout lags raddr by one cycle, so READ checks the previous address and DRAIN
    // checks the final one (addr_q holds there).
    always_comb begin
        cmp_en   = 1'b0;
        cmp_addr = addr_q;
        if (state_q == S_READ && addr_q != '0) begin
            cmp_en   = 1'b1;
            cmp_addr = addr_q - ADDR_W'(1);
        end else if (state_q == S_DRAIN) begin
            cmp_en   = 1'b1;
        end
        mismatch = cmp_en && (dout != pat(mode_q, cmp_addr));
    end

    // Datapath: address counter, latched mode, error statistics.
    always_comb begin
        addr_d  = addr_q;
        mode_d  = mode_q;
        err_d   = err_q;
        first_d = first_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_d  = '0;
                    mode_d  = mode;
                    err_d   = '0;
                    first_d = '0;
                end
            end
            S_WRITE: addr_d = addr_last ? '0 : addr_q + ADDR_W'(1);
            S_READ:  if (!addr_last) addr_d = addr_q + ADDR_W'(1);
            default: ;
        endcase
        if (mismatch) begin
            if (err_q == '0) first_d = cmp_addr;
            if (err_q != ERR_MAX) err_d = err_q + (ADDR_W+1)'(1);
        end
    end

    // Outputs. The RAM writes on every clock, so waddr/din always point at a word
    // together with that word's own pattern.
    always_comb begin
        busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
        done           = (state_q == S_DONE);
        pass           = done && (err_q == '0);
        err_count      = err_q;
        first_err_addr = first_q;
        raddr          = addr_q;
        waddr          = addr_q;
        din            = pat(mode_q, addr_q);
    end

endmodule

// File: tb/tb_bram_sweep_tester.sv
// Bench for bram_sweep_tester: behavioural RAM with read-data fault injection,
// table-driven directed sweeps, a mid-sweep reset and randomized sweeps.
module tb_bram_sweep_tester;

    localparam int WID   = 1;
    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     mode;
    logic           busy, done, pass;
    logic [AW:0]    err_count;
    logic [AW-1:0]  first_err_addr, raddr, waddr;
    logic [WID-1:0] din, dout;

    int total = 0;
    int bad   = 0;

    logic [WID-1:0] ram [DEPTH];
    logic [WID-1:0] ram_q;
    logic [AW-1:0]  ret_addr;
    bit             flip [DEPTH];

    bram_sweep_tester #(.WID_MEM(WID), .DEPTH_MEM(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .raddr(raddr), .waddr(waddr),
        .din(din), .dout(dout)
    );

    always #5 clk = ~clk;

    // Read-first RAM, no write enable; returned data may be corrupted per address.
    always @(posedge clk) begin
        ram_q       <= ram[raddr];
        ram[waddr]  <= din;
        ret_addr    <= raddr;
    end
    assign dout = ram_q ^ {WID{flip[ret_addr]}};

    typedef struct {
        string name;
        int    m;
        bit    hold;
        int    pulse;
        int    fa;
        int    fb;
        bit    inv;
        int    exp_err;
        int    exp_first;
    } vec_t;

    vec_t vt[8];

    function automatic logic [WID-1:0] exp_pat(input int m, input int a);
        case (m)
            0:       return '0;
            1:       return '1;
            2:       return WID'(a % 2);
            default: return WID'((a % 2 == 0) ? 1 : 0);
        endcase
    endfunction

    function automatic int model_err();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (flip[i]) n++;
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    function automatic int model_first();
        for (int i = 0; i < DEPTH; i++) if (flip[i]) return i;
        return 0;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, " busy"}, busy, 0);
        check({name, " done"}, done, 0);
        check({name, " pass"}, pass, 0);
        check({name, " err_count"}, err_count, 0);
        check({name, " first_err"}, first_err_addr, 0);
        check({name, " raddr"}, raddr, 0);
        check({name, " waddr"}, waddr, 0);
        check({name, " din"}, din, 0);
    endtask

    task automatic set_flips(input int a, input int b, input bit all);
        for (int i = 0; i < DEPTH; i++) flip[i] = all;
        if (a >= 0) flip[a] = 1'b1;
        if (b >= 0) flip[b] = 1'b1;
    endtask

    // Entered and left on a negedge; the sweep starts at the following posedge.
    task automatic sweep(input string name, input int m, input bit hold, input int pulse_at,
                         input int exp_err, input int exp_first);
        int wr_bad   = 0;
        int rd_bad   = 0;
        int busy_cnt = 0;
        int done_cyc = -1;
        start = 1'b1;
        mode  = 2'(m);
        @(posedge clk);
        for (int c = 1; c <= 2 * DEPTH + 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!hold) start = 1'b0;
                mode = 2'($urandom_range(0, 3));
            end
            if (c == pulse_at) start = 1'b1;
            if (c == pulse_at + 1) start = 1'b0;
            if (c <= DEPTH) begin
                if (waddr !== AW'(c - 1) || din !== exp_pat(m, c - 1)) wr_bad++;
            end else if (c <= 2 * DEPTH) begin
                if (raddr !== AW'(c - 1 - DEPTH) || waddr !== raddr ||
                    din !== exp_pat(m, c - 1 - DEPTH)) rd_bad++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        check({name, " write_seq_errs"}, wr_bad, 0);
        check({name, " read_seq_errs"}, rd_bad, 0);
        check({name, " done_cycle"}, done_cyc, 2 * DEPTH + 2);
        check({name, " busy_cycles"}, busy_cnt, 2 * DEPTH + 1);
        check({name, " err_count"}, err_count, exp_err);
        check({name, " first_err"}, first_err_addr, exp_first);
        check({name, " pass"}, pass, (exp_err == 0) ? 1 : 0);
    endtask

    initial begin
        vt[0] = '{"m0_single",     0, 1'b0, -1,  -1,  -1, 1'b0,   0, 0};
        vt[1] = '{"m1_b2b",        1, 1'b1, -1,  -1,  -1, 1'b0,   0, 0};
        vt[2] = '{"m2_b2b",        2, 1'b1, -1,  -1,  -1, 1'b0,   0, 0};
        vt[3] = '{"m3_b2b",        3, 1'b0, -1,  -1,  -1, 1'b0,   0, 0};
        vt[4] = '{"m2_flip5_9",    2, 1'b0, -1,   9,   5, 1'b0,   2, 5};
        vt[5] = '{"m0_inv_all",    0, 1'b0, -1,  -1,  -1, 1'b1, 128, 0};
        vt[6] = '{"m3_busy_pulse", 3, 1'b0, 149, -1,  -1, 1'b0,   0, 0};
        vt[7] = '{"m1_flip_ends",  1, 1'b0, -1, 127,   0, 1'b0,   2, 0};

        reset = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        set_flips(-1, -1, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);
        check("idle done", done, 0);

        for (int i = 0; i < 8; i++) begin
            set_flips(vt[i].fa, vt[i].fb, vt[i].inv);
            sweep(vt[i].name, vt[i].m, vt[i].hold, vt[i].pulse, vt[i].exp_err, vt[i].exp_first);
        end

        // Reset during WRITE at k=40, then a clean mode-1 sweep.
        set_flips(-1, -1, 1'b0);
        start = 1'b1;
        mode  = 2'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (41) @(negedge clk);
        check("pre_reset waddr", waddr, 40);
        check("pre_reset busy", busy, 1);
        reset = 1'b1;
        start = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        check_reset_vals("mid_reset_held");
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        sweep("rst_recover", 1, 1'b0, -1, 0, 0);

        for (int r = 0; r < 8; r++) begin
            int m;
            int k;
            m = $urandom_range(0, 3);
            set_flips(-1, -1, ($urandom_range(0, 7) == 0));
            k = $urandom_range(0, 4);
            for (int j = 0; j < k; j++) flip[$urandom_range(0, DEPTH - 1)] = 1'b1;
            sweep($sformatf("rand%0d_m%0d", r, m), m, (r < 7) ? bit'($urandom_range(0, 1)) : 1'b0,
                  -1, model_err(), model_first());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
